// File: rtl/reg_file_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rf_pkg
// Brief   : Shared ABI register indices and clear-sequencer state encoding.
// Rev     : 1.0
// ============================================================================
package rf_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 1;
  localparam int REG_SP   = 2;
  localparam int REG_GP   = 3;
  localparam int REG_TP   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } rf_clr_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_mp_if
// Brief   : Read/write/clear bus between the core pipeline and reg_file_mp.
// Rev     : 1.0
// ============================================================================
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);

  logic                     RegWrite;
  logic                     wr_ready;
  logic [ADDR_W-1:0]        WriteRegister;
  logic [DATA_W-1:0]        WriteData;
  logic [NUM_RD*ADDR_W-1:0] ReadRegister;
  logic [NUM_RD*DATA_W-1:0] ReadData;
  logic                     clear_req;
  logic                     busy;
  logic                     clear_done;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister, clear_req,
    input  wr_ready, ReadData, busy, clear_done
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister, clear_req,
    output wr_ready, ReadData, busy, clear_done
  );

endinterface
`default_nettype wire

// File: rtl/reg_file_mp_clear_seq.sv
`default_nettype none
// ============================================================================
// Module  : rf_clear_seq
// Brief   : Bulk-clear sequencer, walks indices 1..2**ADDR_W-1 one per cycle.
// Rev     : 1.0
// ============================================================================
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              clear_req,
  output logic                   clr_we,
  output logic [ADDR_W-1:0]      clr_idx,
  output logic                   busy,
  output logic                   clear_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  rf_clr_state_t     state, state_next;
  logic [ADDR_W-1:0] idx_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = clr_idx;
    clr_we     = 1'b0;
    busy       = 1'b0;
    clear_done = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
          idx_next   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        busy   = 1'b1;
        // Hold the index at the top entry instead of wrapping back to x0.
        if (clr_idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next = clr_idx + ADDR_W'(1);
        end
      end
      DONE: begin
        clear_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_mp
// Brief   : RV32 register file, NUM_RD read ports, one write port, bulk clear.
//           REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
// Rev     : 1.0
// ============================================================================
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int SP_RESET = 124
) (
  input  wire logic     clk,
  input  wire logic     reset,
  reg_file_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              seq_busy;
  logic              port_we;

  function automatic logic [DATA_W-1:0] reset_val(input logic [ADDR_W-1:0] idx);
    return (idx == ADDR_W'(REG_SP)) ? DATA_W'(SP_RESET) : '0;
  endfunction

  rf_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (bus.clear_req),
    .clr_we     (clr_we),
    .clr_idx    (clr_idx),
    .busy       (seq_busy),
    .clear_done (bus.clear_done)
  );

  assign bus.busy     = seq_busy;
  assign bus.wr_ready = ~seq_busy;
  assign port_we      = bus.RegWrite & bus.wr_ready & (bus.WriteRegister != '0);

  // x0 storage is never written: the clear walk starts at 1 and port writes to 0 are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= reset_val(ADDR_W'(i));
      end
    end else if (clr_we) begin
      regs[clr_idx] <= reset_val(clr_idx);
    end else if (port_we) begin
      regs[bus.WriteRegister] <= bus.WriteData;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = bus.ReadRegister[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = regs[ra];
`ifdef REGFILE_BYPASS_EN
      if (port_we && (bus.WriteRegister == ra)) begin
        rd = bus.WriteData;
      end
`endif
      if (ra == ADDR_W'(REG_ZERO)) begin
        rd = '0;
      end
    end

    assign bus.ReadData[k*DATA_W +: DATA_W] = rd;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_file_mp
// Brief   : Scoreboard bench for reg_file_mp (reads, writes, clear, reset).
// Rev     : 1.0
// ============================================================================
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int SP = 124;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } rd_exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] model [32];
  rd_exp_t     sb [$];
  int          checks;
  int          errors;

  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .SP_RESET(SP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rst_val(input int i);
    return (i == 2) ? 32'(SP) : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = rst_val(i);
  endtask

  task automatic expect_rd(input int port, input int addr, input logic [31:0] exp, input string tag);
    logic [4:0] a;
    a = addr[4:0];
    bus.ReadRegister[port*AW +: AW] = a;
    sb.push_back('{$sformatf("%s_p%0d_x%0d", tag, port, addr), port, exp});
  endtask

  task automatic drain();
    rd_exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, bus.ReadData[e.port*DW +: DW], e.exp);
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      expect_rd(0, i, model[i], tag);
      expect_rd(1, 31 - i, model[31 - i], tag);
      drain();
    end
  endtask

  task automatic write_reg(input int a, input logic [31:0] d);
    logic [4:0] wa;
    wa = a[4:0];
    @(negedge clk);
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = wa;
    bus.WriteData     = d;
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
    if (a != 0) model[a] = d;
  endtask

  task automatic start_clear();
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    reset             = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = '0;
    bus.WriteData     = '0;
    bus.ReadRegister  = '0;
    bus.clear_req     = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.clear_done), 32'd0);
    read_all("rst");

    // Basic write/read, x0 discard
    write_reg(5, 32'hDEADBEEF);
    expect_rd(0, 5, 32'hDEADBEEF, "wr5");
    expect_rd(1, 5, 32'hDEADBEEF, "wr5");
    drain();
    write_reg(0, 32'h1234);
    expect_rd(0, 0, 32'h0, "wr0");
    expect_rd(1, 0, 32'h0, "wr0");
    drain();

    // Same-cycle write and read
    @(negedge clk);
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd7;
    bus.WriteData     = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
    expect_rd(0, 7, 32'hA5A5A5A5, "same_cyc");
`else
    expect_rd(0, 7, model[7], "same_cyc");
`endif
    expect_rd(1, 5, 32'hDEADBEEF, "same_cyc_other");
    drain();
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
    model[7] = 32'hA5A5A5A5;
    expect_rd(0, 7, 32'hA5A5A5A5, "next_cyc");
    drain();
    @(negedge clk);
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd0;
    bus.WriteData     = 32'hFFFFFFFF;
    expect_rd(0, 0, 32'h0, "same_cyc_x0");
    drain();
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;

    // Fill and bulk clear
    for (int i = 1; i < 32; i++) write_reg(i, 32'(i * 32'h11));
    read_all("fill");
    start_clear();
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      chk($sformatf("clr_busy_c%0d", c), 32'(bus.busy), 32'd1);
      chk($sformatf("clr_wr_ready_c%0d", c), 32'(bus.wr_ready), 32'd0);
      chk($sformatf("clr_done_c%0d", c), 32'(bus.clear_done), 32'd0);
      expect_rd(0, c - 1, rst_val(c - 1), "clr_done_entry");
      expect_rd(1, c, model[c], "clr_pending_entry");
      drain();
    end
    @(negedge clk);
    chk("clr_done_c32", 32'(bus.clear_done), 32'd1);
    chk("clr_busy_c32", 32'(bus.busy), 32'd0);
    chk("clr_wr_ready_c32", 32'(bus.wr_ready), 32'd1);
    model_reset();
    @(negedge clk);
    chk("clr_done_c33", 32'(bus.clear_done), 32'd0);
    read_all("after_clr");

    // Write held through CLEAR, re-requested clear ignored
    start_clear();
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd9;
    bus.WriteData     = 32'h55;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      if (c == 5) bus.clear_req = 1'b1;
      if (c == 8) bus.clear_req = 1'b0;
      chk($sformatf("hold_busy_c%0d", c), 32'(bus.busy), 32'd1);
      expect_rd(0, 9, 32'h0, "hold_x9");
      drain();
    end
    @(negedge clk);
    chk("hold_done", 32'(bus.clear_done), 32'd1);
    chk("hold_wr_ready", 32'(bus.wr_ready), 32'd1);
`ifdef REGFILE_BYPASS_EN
    expect_rd(0, 9, 32'h55, "hold_done_x9");
`else
    expect_rd(0, 9, 32'h0, "hold_done_x9");
`endif
    drain();
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
    model[9] = 32'h55;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("no_second_busy_%0d", c), 32'(bus.busy), 32'd0);
      chk($sformatf("no_second_done_%0d", c), 32'(bus.clear_done), 32'd0);
    end
    read_all("after_hold");

    // Reset in the middle of a clear
    write_reg(20, 32'h2020);
    write_reg(3, 32'h3333);
    write_reg(31, 32'hFFFF0000);
    start_clear();
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("mid_rst_done", 32'(bus.clear_done), 32'd0);
    model_reset();
    read_all("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    write_reg(3, 32'h77);
    expect_rd(0, 3, 32'h77, "post_rst");
    expect_rd(1, 2, 32'(SP), "post_rst");
    drain();
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
